cpu16_bus_responder: RTL and testbench

- Responder end of the CPU16 memory bus. It answers the CPU's address/data_out/write signals with registered read data on data_in.
- Hosts data RAM, program RAM, and a memory-mapped keyboard block.
- Feeds the CPU's keycode input from a small key FIFO and consumes the CPU's keystrobe acknowledge.
- Sits between CPU16 and the board-level keyboard scanner.

---
 rtl/cpu16_bus_pkg.sv | 17 +
 rtl/cpu16_bus_responder_key_fifo.sv | 73 +++++++
 rtl/cpu16_bus_responder.sv | 110 +++++++++++
 tb/tb_cpu16_bus_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu16_bus_pkg.sv
// Shared constants for the CPU16 bus responder: MMIO addresses,
// region bases and KEYSTAT bit positions.
package cpu16_bus_pkg;

  localparam logic [15:0] ADDR_KEYDATA = 16'hFF00;
  localparam logic [15:0] ADDR_KEYSTAT = 16'hFF01;
  localparam logic [15:0] ADDR_TIMER   = 16'hFF02;

  localparam logic [15:0] DRAM_BASE   = 16'h0000;
  localparam logic [15:0] PRAM_BASE   = 16'h4000;
  localparam logic [15:0] REGION_MASK = 16'hC000;

  localparam int KSTAT_NEMPTY = 0;
  localparam int KSTAT_FULL   = 1;
  localparam int KSTAT_OVF    = 2;

endpackage

// File: rtl/cpu16_bus_responder_key_fifo.sv
// key_fifo: keyboard code FIFO with registered head, full/empty, sticky overflow.
// Ports: clk, reset (sync active-low), code/push_req, pop_req, ovf_clr -> head, full, empty, overflow.
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code,
  input  logic       push_req,
  input  logic       pop_req,
  input  logic       ovf_clr,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [7:0]    head_q, head_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push, pop, ovf_set;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign head     = head_q;
  assign overflow = ovf_q;

  always_comb begin
    pop     = pop_req && !empty;
    // a pop frees a slot, so a full FIFO still accepts a simultaneous push
    push    = push_req && (!full || pop);
    ovf_set = push_req && full && !pop;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
    ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    // next head: bypass the incoming code when it lands at the new read slot
    head_d  = 8'h00;
    if (cnt_d != '0) begin
      if (push && rd_d == wr_q) head_d = code;
      else                      head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_q] <= code;
  end

endmodule

// File: rtl/cpu16_bus_responder.sv
// cpu16_bus_responder: CPU16 bus slave with data RAM, program RAM, keyboard MMIO.
// Ports: clk, reset (sync active-low), address/data_out/write -> data_in; keycode/keystrobe;
// kbd_code/kbd_valid -> kbd_overflow. Define CPU16_BUS_TIMER_EN for the tick counter at 0xFF02.
module cpu16_bus_responder
  import cpu16_bus_pkg::*;
#(
  parameter int    RAM_AW    = 10,
  parameter int    PROG_AW   = 12,
  parameter string PROG_FILE = "",
  parameter int    KEY_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  input  logic        write,
  output logic [15:0] data_in,
  output logic [7:0]  keycode,
  input  logic        keystrobe,
  input  logic [7:0]  kbd_code,
  input  logic        kbd_valid,
  output logic        kbd_overflow
);

  logic [15:0] dram_q [2**RAM_AW];
  logic [15:0] pram_q [2**PROG_AW];

  logic [15:0] data_in_q, data_in_d;
  logic        ks_q, ks_d;
  logic        dram_sel, pram_sel;
  logic        pop_req, ovf_clr;
  logic        full, empty;
  logic [15:0] stat;

  key_fifo #(.DEPTH(KEY_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .code     (kbd_code),
    .push_req (kbd_valid),
    .pop_req  (pop_req),
    .ovf_clr  (ovf_clr),
    .head     (keycode),
    .full     (full),
    .empty    (empty),
    .overflow (kbd_overflow)
  );

`ifdef CPU16_BUS_TIMER_EN
  logic [15:0] tick_q, tick_d;

  always_comb begin
    tick_d = tick_q + 16'd1;
    if (write && address == ADDR_TIMER) tick_d = data_out;
  end

  always_ff @(posedge clk) begin
    if (!reset) tick_q <= '0;
    else        tick_q <= tick_d;
  end
`endif

  always_comb begin
    dram_sel = (address & REGION_MASK) == DRAM_BASE;
    pram_sel = (address & REGION_MASK) == PRAM_BASE;
    ks_d     = keystrobe;
    pop_req  = keystrobe && !ks_q;
    ovf_clr  = write && address == ADDR_KEYSTAT && data_out[KSTAT_OVF];
    stat     = '0;
    stat[KSTAT_NEMPTY] = !empty;
    stat[KSTAT_FULL]   = full;
    stat[KSTAT_OVF]    = kbd_overflow;
    data_in_d = '0;
    unique case (1'b1)
      dram_sel:
        data_in_d = write ? data_out : dram_q[address[RAM_AW-1:0]];
      pram_sel:
        data_in_d = write ? data_out : pram_q[address[PROG_AW-1:0]];
      (address == ADDR_KEYDATA):
        data_in_d = {8'h00, keycode};
      (address == ADDR_KEYSTAT):
        data_in_d = stat;
`ifdef CPU16_BUS_TIMER_EN
      (address == ADDR_TIMER):
        data_in_d = tick_q;
`endif
      default:
        data_in_d = '0;
    endcase
  end

  assign data_in = data_in_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_in_q <= '0;
      ks_q      <= 1'b0;
    end else begin
      data_in_q <= data_in_d;
      ks_q      <= ks_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && write && dram_sel)
      dram_q[address[RAM_AW-1:0]] <= data_out;
    if (reset && write && pram_sel)
      pram_q[address[PROG_AW-1:0]] <= data_out;
  end

endmodule

// File: tb/tb_cpu16_bus_responder.sv
// Directed self-checking bench for cpu16_bus_responder.
// Default parameters: RAM_AW=10, PROG_AW=12, KEY_DEPTH=4.
module tb_cpu16_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        write;
  logic [15:0] data_in;
  logic [7:0]  keycode;
  logic        keystrobe;
  logic [7:0]  kbd_code;
  logic        kbd_valid;
  logic        kbd_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu16_bus_responder dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .data_out     (data_out),
    .write        (write),
    .data_in      (data_in),
    .keycode      (keycode),
    .keystrobe    (keystrobe),
    .kbd_code     (kbd_code),
    .kbd_valid    (kbd_valid),
    .kbd_overflow (kbd_overflow)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c);
    kbd_code  = c;
    kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
  endtask

  task automatic pop();
    keystrobe = 1'b1;
    tick();
    keystrobe = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address  = a;
    data_out = d;
    write    = 1'b1;
    tick();
    write    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a,
                    input logic [15:0] exp);
    address = a;
    tick();
    check(tag, data_in, exp);
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    reset = 1'b0; address = '0; data_out = '0; write = 1'b0;
    keystrobe = 1'b0; kbd_code = '0; kbd_valid = 1'b0;
    tick();
    tick();
    check("rst_data_in", data_in, 16'h0000);
    check("rst_keycode", {8'h00, keycode}, 16'h0000);
    check("rst_ovf", {15'b0, kbd_overflow}, 16'h0000);
    reset = 1'b1;

    wr(16'h0005, 16'h1234);
    rd("dram_rd", 16'h0005, 16'h1234);
    rd("dram_alias", 16'h0405, 16'h1234);
    wr(16'h4010, 16'hCAFE);
    rd("pram_alias", 16'h5010, 16'hCAFE);

    rd("unmap_8000", 16'h8000, 16'h0000);
    rd("unmap_ff7f", 16'hFF7F, 16'h0000);
    wr(16'h8000, 16'hBEEF);
    rd("unmap_wr", 16'h8000, 16'h0000);
    rd("keydata_empty", 16'hFF00, 16'h0000);

    push(8'h41);
    push(8'h42);
    push(8'h43);
    check("keycode_41", {8'h00, keycode}, 16'h0041);
    rd("keystat_3", 16'hFF01, 16'h0001);
    rd("keydata_41", 16'hFF00, 16'h0041);

    keystrobe = 1'b1;
    repeat (3) tick();
    keystrobe = 1'b0;
    tick();
    check("one_pop", {8'h00, keycode}, 16'h0042);

    push(8'h44);
    push(8'h45);
    push(8'h46);
    check("ovf_set", {15'b0, kbd_overflow}, 16'h0001);
    rd("keystat_ovf", 16'hFF01, 16'h0007);
    wr(16'hFF01, 16'h0004);
    rd("keystat_clr", 16'hFF01, 16'h0003);

    kbd_code = 8'h47; kbd_valid = 1'b1;
    wr(16'hFF01, 16'h0004);
    kbd_valid = 1'b0;
    check("ovf_set_wins", {15'b0, kbd_overflow}, 16'h0001);

    wr(16'hFF01, 16'h0004);
    kbd_code = 8'h50; kbd_valid = 1'b1; keystrobe = 1'b1;
    tick();
    kbd_valid = 1'b0; keystrobe = 1'b0;
    tick();
    check("full_pp_ovf", {15'b0, kbd_overflow}, 16'h0000);
    check("full_pp_head", {8'h00, keycode}, 16'h0043);
    rd("full_pp_stat", 16'hFF01, 16'h0003);

    drain_exp[0] = 8'h44;
    drain_exp[1] = 8'h45;
    drain_exp[2] = 8'h50;
    drain_exp[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      pop();
      check($sformatf("drain%0d", i), {8'h00, keycode},
            {8'h00, drain_exp[i]});
    end
    rd("empty_stat", 16'hFF01, 16'h0000);

    kbd_code = 8'h60; kbd_valid = 1'b1; keystrobe = 1'b1;
    tick();
    kbd_valid = 1'b0; keystrobe = 1'b0;
    tick();
    check("empty_pp_head", {8'h00, keycode}, 16'h0060);
    rd("empty_pp_stat", 16'hFF01, 16'h0001);

    wr(16'h0007, 16'h1111);
    push(8'h61);
    push(8'h62);
    push(8'h63);
    push(8'h64);
    check("pre_rst_ovf", {15'b0, kbd_overflow}, 16'h0001);
    reset = 1'b0;
    address = 16'h0007; data_out = 16'h2222; write = 1'b1;
    kbd_code = 8'h65; kbd_valid = 1'b1;
    tick();
    reset = 1'b1; write = 1'b0; kbd_valid = 1'b0;
    check("mid_rst_keycode", {8'h00, keycode}, 16'h0000);
    check("mid_rst_ovf", {15'b0, kbd_overflow}, 16'h0000);
    check("mid_rst_data_in", data_in, 16'h0000);
    rd("mid_rst_ram", 16'h0007, 16'h1111);
    rd("mid_rst_stat", 16'hFF01, 16'h0000);

`ifdef CPU16_BUS_TIMER_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    address = 16'hFF02;
    tick();
    check("tmr0", data_in, 16'h0000);
    tick();
    check("tmr1", data_in, 16'h0001);
    tick();
    check("tmr2", data_in, 16'h0002);
    wr(16'hFF02, 16'h1000);
    tick();
    check("tmr_load", data_in, 16'h1000);
    tick();
    check("tmr_inc", data_in, 16'h1001);
`else
    wr(16'hFF02, 16'h1000);
    rd("ff02_unmap", 16'hFF02, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
